// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter: WIDTH-bit shift counter, run-time selectable between a
// one-hot ring sequence and a Johnson (twisted-ring) sequence. Supports enable,
// up/down stepping, parallel load, a wrap pulse and self-correction of illegal
// states with an error pulse. pos is a combinational index of the current state.
module ring_johnson_counter #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    pos,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] RING_HOME = WIDTH'(1);
  localparam logic [PW-1:0]    RING_LAST = PW'(WIDTH-1);
  localparam logic [PW-1:0]    JOHN_LAST = PW'(2*WIDTH-1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  // Ring: exactly one bit set. Johnson: thermometer, at most one adjacent change.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    int ones;
    int edges;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + (v[i] ? 1 : 0);
    end
    for (int i = 0; i < WIDTH-1; i++) begin
      edges = edges + ((v[i] != v[i+1]) ? 1 : 0);
    end
    return m ? (edges <= 1) : (ones == 1);
  endfunction

  // Sequence index of a state; illegal states map to 0.
  function automatic logic [PW-1:0] pos_of(input logic [WIDTH-1:0] v, input logic m);
    logic [PW-1:0] p;
    int            ones;
    p    = '0;
    ones = 0;
    if (is_legal(v, m)) begin
      if (!m) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (v[i]) p = PW'(i);
        end
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          ones = ones + (v[i] ? 1 : 0);
        end
        p = v[WIDTH-1] ? PW'(2*WIDTH - ones) : PW'(ones);
      end
    end
    return p;
  endfunction

  // One shift step of the legal sequence in the selected mode and direction.
  function automatic logic [WIDTH-1:0] step_of(input logic [WIDTH-1:0] v, input logic m,
                                               input logic d);
    logic [WIDTH-1:0] n;
    if (!d) n = {v[WIDTH-2:0], (m ? ~v[WIDTH-1] : v[WIDTH-1])};
    else    n = {(m ? ~v[0] : v[0]), v[WIDTH-1:1]};
    return n;
  endfunction

  // State register: count plus the registered wrap/err pulses, async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RING_HOME;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // Next state: load beats enable; illegal states are corrected on an enabled step.
  always_comb begin
    logic [WIDTH-1:0] nxt;
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    nxt     = step_of(count_q, mode, dir);
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (!is_legal(count_q, mode)) begin
        count_d = mode ? '0 : RING_HOME;
        err_d   = 1'b1;
      end else begin
        count_d = nxt;
        if (!dir) wrap_d = (pos_of(nxt, mode) == '0);
        else      wrap_d = (pos_of(nxt, mode) == (mode ? JOHN_LAST : RING_LAST));
      end
    end
  end

  // Outputs: pos follows count and mode with no register in between.
  always_comb begin
    pos = pos_of(count_q, mode);
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Bench for ring_johnson_counter (WIDTH = 4): a sequence-table model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_ring_johnson_counter;

  localparam int W  = 4;
  localparam int PW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          dir;
  logic          mode;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  count;
  logic [PW-1:0] pos;
  logic          wrap;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  ring_johnson_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .count(count), .pos(pos), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  // k-th state of the sequence: ring = 1<<k, Johnson = fill ones then drain them.
  function automatic logic [W-1:0] seq_val(input int k, input logic m);
    int full;
    int v;
    full = (1 << W) - 1;
    if (!m)          v = 1 << k;
    else if (k <= W) v = (1 << k) - 1;
    else             v = full ^ ((1 << (k - W)) - 1);
    return W'(v);
  endfunction

  function automatic int seq_len(input logic m);
    return m ? 2*W : W;
  endfunction

  // Position of v in the mode's sequence, -1 if v is not a member.
  function automatic int find_idx(input logic [W-1:0] v, input logic m);
    for (int k = 0; k < seq_len(m); k++) begin
      if (seq_val(k, m) == v) return k;
    end
    return -1;
  endfunction

  logic [W-1:0] m_count;
  logic         m_wrap;
  logic         m_err;
  int           m_idx;
  int           m_ni;
  int           m_len;

  // Reference model: walks an index through the sequence table.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count <= W'(1);
      m_wrap  <= 1'b0;
      m_err   <= 1'b0;
    end else if (load) begin
      m_count <= load_val;
      m_wrap  <= 1'b0;
      m_err   <= 1'b0;
    end else if (en) begin
      m_idx = find_idx(m_count, mode);
      m_len = seq_len(mode);
      if (m_idx < 0) begin
        m_count <= mode ? W'(0) : W'(1);
        m_wrap  <= 1'b0;
        m_err   <= 1'b1;
      end else begin
        m_ni    = dir ? (m_idx + m_len - 1) % m_len : (m_idx + 1) % m_len;
        m_count <= seq_val(m_ni, mode);
        m_wrap  <= dir ? (m_ni == m_len - 1) : (m_ni == 0);
        m_err   <= 1'b0;
      end
    end else begin
      m_wrap <= 1'b0;
      m_err  <= 1'b0;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    int e_pos;
    e_pos = find_idx(m_count, mode);
    if (e_pos < 0) e_pos = 0;
    check("model_count", int'(count), int'(m_count));
    check("model_pos",   int'(pos),   e_pos);
    check("model_wrap",  int'(wrap),  int'(m_wrap));
    check("model_err",   int'(err),   int'(m_err));
  end

  // Apply inputs for one rising edge, then settle just past it.
  task automatic drive(input logic ld, input logic [W-1:0] lv, input logic e,
                       input logic d, input logic m);
    load     = ld;
    load_val = lv;
    en       = e;
    dir      = d;
    mode     = m;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input int c, input int p, input int w,
                            input int e);
    check({name, "_count"}, int'(count), c);
    check({name, "_pos"},   int'(pos),   p);
    check({name, "_wrap"},  int'(wrap),  w);
    check({name, "_err"},   int'(err),   e);
  endtask

  int jc[8] = '{1, 3, 7, 15, 14, 12, 8, 0};

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    #1;
    expect_out("reset", 1, 0, 0, 0);
    #11;
    rst = 1'b0;
    #1;

    // Ring up from reset: 0010, 0100, 1000, 0001 with wrap on the last step.
    drive(0, 0, 1, 0, 0); expect_out("ring_up1", 2, 1, 0, 0);
    drive(0, 0, 1, 0, 0); expect_out("ring_up2", 4, 2, 0, 0);
    drive(0, 0, 1, 0, 0); expect_out("ring_up3", 8, 3, 0, 0);
    drive(0, 0, 1, 0, 0); expect_out("ring_up4", 1, 0, 1, 0);

    // Johnson up after loading 0000.
    drive(1, 4'b0000, 0, 0, 1); expect_out("john_load", 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 0, 1);
      expect_out("john_up", jc[k], (k + 1) % 8, (k == 7) ? 1 : 0, 0);
    end

    // Down steps that wrap backwards.
    drive(1, 4'b0000, 0, 1, 1);
    drive(0, 0, 1, 1, 1); expect_out("john_dn", 8, 7, 1, 0);
    drive(1, 4'b0001, 0, 1, 0);
    drive(0, 0, 1, 1, 0); expect_out("ring_dn", 8, 3, 1, 0);
    drive(0, 0, 1, 1, 0); expect_out("ring_dn2", 4, 2, 0, 0);

    // Illegal state correction.
    drive(1, 4'b0101, 0, 0, 0); expect_out("ill_load", 5, 0, 0, 0);
    drive(0, 0, 1, 0, 0); expect_out("ill_fix", 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0); expect_out("ill_after", 1, 0, 0, 0);
    drive(1, 4'b0100, 0, 0, 0); expect_out("sw_load", 4, 2, 0, 0);
    mode = 1'b1; en = 1'b0; load = 1'b0;
    #1;
    check("sw_pos_illegal", int'(pos), 0);
    drive(0, 0, 1, 0, 1); expect_out("sw_fix", 0, 0, 0, 1);

    // Load wins over enable, then hold.
    drive(1, 4'b1010, 1, 0, 0); expect_out("ld_wins", 10, 0, 0, 0);
    drive(1, 4'b0010, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0); expect_out("hold", 2, 1, 0, 0);
    end

    // Reset between edges mid-sequence, ring then Johnson.
    drive(0, 0, 1, 0, 0); expect_out("pre_rst", 4, 2, 0, 0);
    rst = 1'b1;
    #1;
    expect_out("mid_rst", 1, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 1, 0, 0); expect_out("ring_resume", 2, 1, 0, 0);
    rst = 1'b1; mode = 1'b1;
    #1;
    expect_out("mid_rst_j", 1, 1, 0, 0);
    rst = 1'b0;
    drive(0, 0, 1, 0, 1); expect_out("john_resume", 3, 2, 0, 0);

    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
